// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and constants for the bit-entry front end and sequence detector
// Contents: debounce_state_t (debouncer FSM states), SYNC_STAGES (synchroniser depth),
//           max_int (constant helper for sizing counters)
package seq_det_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: flop-chain synchroniser for one asynchronous input bit
// Ports: clk (sampling clock), rst_n (async active-low reset, chain loads RST_VAL),
//        d (asynchronous input), q (synchronised output)
module sync_2ff
  import seq_det_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {SYNC_STAGES{RST_VAL}};
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/bit_entry_debouncer.sv
// bit_entry_debouncer: synchronises the bit switch, debounces the step key, one ena strobe per press
// Ports: clk (all logic on posedge), rst_n (async active-low reset),
//        key_n (raw active-low pushbutton), sw_bit (raw slide switch),
//        sig_to_test (bit captured at the strobe, held until the next),
//        ena (one-cycle strobe), key_held (debounced key level, 1 = pressed)
// Optional build macro AUTO_REPEAT_EN: repeat the strobe every REPEAT_CYCLES while the key stays pressed.
module bit_entry_debouncer
  import seq_det_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  input  logic sw_bit,
  output logic sig_to_test,
  output logic ena,
  output logic key_held
);
  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic k, s, strobe, armed;
  logic [SYNC_STAGES-1:0] prime;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  debounce_state_t state_q, state_d;

  sync_2ff #(.RST_VAL(1'b1)) u_key_sync (.clk(clk), .rst_n(rst_n), .d(key_n),  .q(k));
  sync_2ff #(.RST_VAL(1'b0)) u_sw_sync  (.clk(clk), .rst_n(rst_n), .d(sw_bit), .q(s));

  // prime fills with ones as real samples displace the synchroniser's reset values.
  // armed is set only once a genuine high key level has been seen in IDLE, so a key
  // held through reset must be released and pressed again before it can strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ena         <= 1'b0;
      sig_to_test <= 1'b0;
      prime       <= '0;
      armed       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ena         <= strobe;
      sig_to_test <= strobe ? s : sig_to_test;
      prime       <= {prime[SYNC_STAGES-2:0], 1'b1};
      armed       <= armed | (state_q == IDLE && k && prime[SYNC_STAGES-1]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strobe  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!k && armed) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (k) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          strobe  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (k) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
`ifdef AUTO_REPEAT_EN
        end else if (cnt_q == REP_MAX) begin
          cnt_d  = '0;
          strobe = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
`else
        end else begin
          cnt_d = '0;
`endif
        end
      end
      RELEASE_WAIT: begin
        if (!k) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    key_held = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  end
endmodule

// File: tb/tb_bit_entry_debouncer.sv
// tb_bit_entry_debouncer: scoreboard bench for bit_entry_debouncer (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
module tb_bit_entry_debouncer;
  localparam int D = 4;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_n = 1'b1;
  logic sw_bit = 1'b0;
  logic sig_to_test, ena, key_held;

  typedef struct {
    int   cyc;
    logic bit_v;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic prev_ena = 1'b0;

  bit_entry_debouncer #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .sw_bit(sw_bit),
    .sig_to_test(sig_to_test), .ena(ena), .key_held(key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every ena must match the head of the expected-strobe queue
  always @(negedge clk) begin
    exp_t e;
    if (ena) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ena: strobe at cycle %0d sig=%0b, none expected", cyc, sig_to_test);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || sig_to_test !== e.bit_v) begin
          miscompares++;
          $display("FAIL strobe: got cycle %0d sig=%0b, expected cycle %0d sig=%0b", cyc, sig_to_test, e.cyc, e.bit_v);
        end
      end
      if (prev_ena) begin
        miscompares++;
        $display("FAIL ena_twice: ena high on consecutive cycles at %0d", cyc);
      end
    end
    prev_ena = ena;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic b);
    exp_t e;
    e.cyc = c;
    e.bit_v = b;
    exp_q.push_back(e);
  endtask

  // Key driven low at negedge of cycle c for h cycles: press strobe, plus repeats while held
  task automatic push_hold(input int c, input int h, input logic b);
    push(c + 3 + D, b);
`ifdef AUTO_REPEAT_EN
    for (int t = c + 3 + D + R; t <= c + h + 2; t += R) push(t, b);
`endif
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected strobes missing (next at cycle %0d)", name, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    vectors++;
    if ({ena, sig_to_test, key_held} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_outputs: ena/sig/held=%b expected 000", {ena, sig_to_test, key_held});
    end
    rst_n = 1'b1;
    step(6);
  endtask

  task automatic test_clean_press();
    int c, r;
    sw_bit = 1'b1;
    step(3);
    c = cyc;
    key_n = 1'b0;
    push_hold(c, 20, 1'b1);
    step(20);
    vectors++;
    if (key_held !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_held: key_held=%b expected 1", key_held);
    end
    key_n = 1'b1;
    r = cyc;
    step(6);
    vectors++;
    if (key_held !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_release6: key_held=%b expected 1 at release+6 (cycle %0d)", key_held, cyc - r);
    end
    step(1);
    vectors++;
    if (key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_release7: key_held=%b expected 0 at release+7", key_held);
    end
    vectors++;
    if (sig_to_test !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_sig: sig_to_test=%b expected 1", sig_to_test);
    end
    step(3);
    check_drained("clean_drain");
  endtask

  task automatic test_bounce();
    sw_bit = 1'b0;
    key_n = 1'b0;
    step(2);
    key_n = 1'b1;
    step(1);
    key_n = 1'b0;
    step(2);
    key_n = 1'b1;
    step(10);
    vectors++;
    if (key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_held: key_held=%b expected 0", key_held);
    end
    vectors++;
    if (sig_to_test !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_sig: sig_to_test=%b expected 1 (unchanged)", sig_to_test);
    end
    check_drained("bounce_drain");
  endtask

  task automatic test_release_bounce();
    int c;
    sw_bit = 1'b0;
    step(3);
    c = cyc;
    key_n = 1'b0;
    push_hold(c, 10, 1'b0);
    step(10);
    key_n = 1'b1;
    step(1);
    key_n = 1'b0;
    step(1);
    key_n = 1'b1;
    step(15);
    vectors++;
    if (key_held !== 1'b0 || sig_to_test !== 1'b0) begin
      miscompares++;
      $display("FAIL release_bounce: held=%b sig=%b expected held=0 sig=0", key_held, sig_to_test);
    end
    check_drained("release_bounce_drain");
  endtask

  task automatic test_sequence();
    int c;
    logic [4:0] pattern;
    pattern = 5'b10010;
    for (int i = 0; i < 5; i++) begin
      sw_bit = pattern[i];
      step(3);
      c = cyc;
      key_n = 1'b0;
      push_hold(c, 10, pattern[i]);
      step(9);
      sw_bit = ~pattern[i];
      step(1);
      key_n = 1'b1;
      step(12);
      vectors++;
      if (sig_to_test !== pattern[i]) begin
        miscompares++;
        $display("FAIL seq_bit%0d: sig_to_test=%b expected %b", i, sig_to_test, pattern[i]);
      end
    end
    check_drained("seq_drain");
  endtask

  task automatic test_reset_mid();
    int c;
    sw_bit = 1'b1;
    step(3);
    key_n = 1'b0;
    step(5);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ena, sig_to_test, key_held} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_async: ena/sig/held=%b expected 000", {ena, sig_to_test, key_held});
    end
    step(1);
    rst_n = 1'b1;
    step(15);
    vectors++;
    if (key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held_key: key_held=%b expected 0", key_held);
    end
    check_drained("reset_no_ena");
    key_n = 1'b1;
    step(5);
    c = cyc;
    key_n = 1'b0;
    push_hold(c, 10, 1'b1);
    step(10);
    key_n = 1'b1;
    step(12);
    vectors++;
    if (sig_to_test !== 1'b1) begin
      miscompares++;
      $display("FAIL repress_sig: sig_to_test=%b expected 1", sig_to_test);
    end
    check_drained("repress_drain");
  endtask

  task automatic test_auto_repeat();
    int c;
    logic last;
    sw_bit = 1'b1;
    step(3);
    c = cyc;
    key_n = 1'b0;
    push(c + 7, 1'b1);
`ifdef AUTO_REPEAT_EN
    push(c + 15, 1'b0);
    push(c + 23, 1'b0);
    last = 1'b0;
`else
    last = 1'b1;
`endif
    step(10);
    sw_bit = 1'b0;
    step(16);
    key_n = 1'b1;
    step(12);
    vectors++;
    if (sig_to_test !== last) begin
      miscompares++;
      $display("FAIL repeat_sig: sig_to_test=%b expected %b", sig_to_test, last);
    end
    check_drained("repeat_drain");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_sequence();
    test_reset_mid();
    test_auto_repeat();
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
